// File: rtl/sr_shifter.sv
// sr_shifter: serial shift-register transmitter for a 74HC595-style chain.
// Accepts a parallel word on a load request and clocks it out on o_sdata/o_sclk,
// holding o_srbusy high for the whole transfer and pulsing o_done at the end.
// Build option: define SR_LSB_FIRST_EN to shift bit 0 out first (register shifts
// right); by default bit WIDTH-1 goes first and the register shifts left.
module sr_shifter #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_srload,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_srbusy,
   output logic             o_sdata,
   output logic             o_sclk,
   output logic             o_done
);

   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOW    = 2'd1,
      S_HIGH   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_next;
   logic [WIDTH-1:0] w_shreg_shifted;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_next;
   logic             w_bit_next;
   logic             w_xfer_next;

   logic             r_srbusy;
   logic             r_sdata;
   logic             r_sclk;
   logic             r_done;

`ifdef SR_LSB_FIRST_EN
   assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
   assign w_bit_next      = w_shreg_next[0];
`else
   assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
   assign w_bit_next      = w_shreg_next[WIDTH-1];
`endif

   // The line is driven during both clock phases of every bit.
   assign w_xfer_next = (w_state_next == S_LOW) || (w_state_next == S_HIGH);

   // State, shift register, bit count and divider registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_div   <= '0;
      end else begin
         r_state <= w_state_next;
         r_shreg <= w_shreg_next;
         r_cnt   <= w_cnt_next;
         r_div   <= w_div_next;
      end
   end

   // Next-state logic: phase timing by divider, bit sequencing by count.
   always_comb begin
      w_state_next = r_state;
      w_shreg_next = r_shreg;
      w_cnt_next   = r_cnt;
      w_div_next   = r_div;
      case (r_state)
         S_IDLE: begin
            if (i_srload) begin
               w_shreg_next = i_data;
               w_cnt_next   = CNT_LAST;
               w_div_next   = '0;
               w_state_next = S_LOW;
            end
         end
         S_LOW: begin
            if (r_div == DIV_LAST) begin
               w_div_next   = '0;
               w_state_next = S_HIGH;
            end else begin
               w_div_next = r_div + DIV_W'(1);
            end
         end
         S_HIGH: begin
            if (r_div == DIV_LAST) begin
               w_div_next = '0;
               if (r_cnt == '0) begin
                  w_state_next = S_FINISH;
               end else begin
                  w_shreg_next = w_shreg_shifted;
                  w_cnt_next   = r_cnt - CNT_W'(1);
                  w_state_next = S_LOW;
               end
            end else begin
               w_div_next = r_div + DIV_W'(1);
            end
         end
         default: begin
            // FINISH lasts one cycle and never accepts a load.
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Outputs registered from the next state so every pin comes from a flop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_srbusy <= 1'b0;
         r_sdata  <= 1'b0;
         r_sclk   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_srbusy <= w_xfer_next;
         r_sdata  <= w_xfer_next ? w_bit_next : 1'b0;
         r_sclk   <= (w_state_next == S_HIGH);
         r_done   <= (w_state_next == S_FINISH);
      end
   end

   assign o_srbusy = r_srbusy;
   assign o_sdata  = r_sdata;
   assign o_sclk   = r_sclk;
   assign o_done   = r_done;

endmodule

// File: tb/tb_sr_shifter.sv
// tb_sr_shifter: directed and randomized transfers against a cycle-level
// reference of the serial waveform derived from word, bit order and timing.
module tb_sr_shifter;

   localparam int W    = 8;
   localparam int C    = 2;
   localparam int BUSY = 2 * C * W;

   logic         clk;
   logic         i_rst;
   logic         i_srload;
   logic [W-1:0] i_data;
   logic         o_srbusy;
   logic         o_sdata;
   logic         o_sclk;
   logic         o_done;

   int n_vec;
   int n_err;

   sr_shifter #(.WIDTH(W), .CLK_DIV(C)) dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_srload (i_srload),
      .i_data   (i_data),
      .o_srbusy (o_srbusy),
      .o_sdata  (o_sdata),
      .o_sclk   (o_sclk),
      .o_done   (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit i of the serial stream (i = 0 is the first bit out).
   function automatic logic exp_bit(input logic [W-1:0] w, input int i);
`ifdef SR_LSB_FIRST_EN
      return w[i];
`else
      return w[W-1-i];
`endif
   endfunction

   // One transfer, sampled on negedges: cycle k=1 is the first cycle after the
   // load edge, k=BUSY+1 is the done cycle, k=BUSY+2 the idle cycle.
   task automatic do_xfer(input logic [W-1:0] word, input bit hold,
                          input int glitch_at, input int rst_at, input string tag);
      int   rises;
      logic prev_sclk;
      logic exp_busy, exp_sclk, exp_sdata, exp_done;
      rises     = 0;
      prev_sclk = 1'b0;
      i_data    = word;
      i_srload  = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= BUSY + 2; k++) begin
         @(negedge clk);
         exp_busy  = (k <= BUSY);
         exp_sclk  = exp_busy && (((k - 1) % (2 * C)) >= C);
         exp_sdata = exp_busy ? exp_bit(word, (k - 1) / (2 * C)) : 1'b0;
         exp_done  = (k == BUSY + 1);
         check({tag, ":busy"}, o_srbusy, exp_busy);
         check({tag, ":sclk"}, o_sclk, exp_sclk);
         check({tag, ":sdata"}, o_sdata, exp_sdata);
         check({tag, ":done"}, o_done, exp_done);
         if (!prev_sclk && o_sclk) rises++;
         prev_sclk = o_sclk;
         if (k == rst_at) begin
            i_rst    = 1'b1;
            i_srload = 1'b0;
            #1;
            check({tag, ":rst_busy"}, o_srbusy, 1'b0);
            check({tag, ":rst_sclk"}, o_sclk, 1'b0);
            check({tag, ":rst_sdata"}, o_sdata, 1'b0);
            check({tag, ":rst_done"}, o_done, 1'b0);
            repeat (3) begin
               @(negedge clk);
               check({tag, ":rst_hold_busy"}, o_srbusy, 1'b0);
               check({tag, ":rst_hold_done"}, o_done, 1'b0);
            end
            i_rst = 1'b0;
            repeat (2) begin
               @(negedge clk);
               check({tag, ":post_rst_busy"}, o_srbusy, 1'b0);
               check({tag, ":post_rst_done"}, o_done, 1'b0);
            end
            $display("xfer %s word=%h reset at busy cycle %0d", tag, word, rst_at);
            return;
         end
         if (hold) begin
            i_srload = 1'b1;
            i_data   = word;
         end else begin
            i_srload = (k == glitch_at);
            i_data   = W'($urandom);
         end
      end
      check({tag, ":rises"}, rises, W);
      $display("xfer %s word=%h hold=%0d glitch=%0d", tag, word, hold, glitch_at);
   endtask

   task automatic idle_gap(input int n, input string tag);
      for (int g = 0; g < n; g++) begin
         @(negedge clk);
         check({tag, ":gap_busy"}, o_srbusy, 1'b0);
         check({tag, ":gap_done"}, o_done, 1'b0);
      end
   endtask

   initial begin
      logic [W-1:0] word;
      bit           hold;
      int           glitch;
      int           rst_at;
      n_vec    = 0;
      n_err    = 0;
      i_rst    = 1'b1;
      i_srload = 1'b1;
      i_data   = '1;
      #2;
      check("reset_busy", o_srbusy, 1'b0);
      check("reset_sclk", o_sclk, 1'b0);
      check("reset_sdata", o_sdata, 1'b0);
      check("reset_done", o_done, 1'b0);
      repeat (3) @(negedge clk);
      check("reset_hold_busy", o_srbusy, 1'b0);
      i_srload = 1'b0;
      i_rst    = 1'b0;
      idle_gap(2, "start");

      do_xfer(8'hA5, 1'b0, 0, 0, "a5");
      do_xfer(8'hFF, 1'b0, 10, 0, "ff_ignore");
      idle_gap(3, "ff_after");
      do_xfer(8'h00, 1'b0, 0, 0, "zero");
      do_xfer(8'h01, 1'b0, BUSY + 1, 0, "finish_ignore");
      idle_gap(2, "fin_after");

      do_xfer(8'h3C, 1'b1, 0, 0, "hold0");
      do_xfer(8'h3C, 1'b1, 0, 0, "hold1");
      do_xfer(8'h3C, 1'b1, 0, 0, "hold2");
      i_srload = 1'b0;
      idle_gap(2, "hold_after");

      do_xfer(8'hA5, 1'b0, 0, 13, "rst13");
      do_xfer(8'h96, 1'b0, 0, 0, "after_rst");

      for (int t = 0; t < 24; t++) begin
         word   = W'($urandom);
         hold   = ($urandom_range(0, 3) == 0);
         glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BUSY + 1)) : 0;
         rst_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, BUSY)) : 0;
         do_xfer(word, hold, glitch, rst_at, "rand");
         if (!hold || rst_at != 0) begin
            i_srload = 1'b0;
            idle_gap(int'($urandom_range(0, 3)), "rand");
         end
      end
      i_srload = 1'b0;
      idle_gap(2, "end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
